// File: rtl/railway_pkg.sv
// Shared definitions for the crossing speed path: default speed scale,
// divider-scheduler FSM states and the round-robin search helper.
package railway_pkg;

    localparam int DEFAULT_SPEED_SCALE = 32'd1000000;

    // Upper bound on crossings the round-robin helper can search.
    localparam int RR_MAX   = 64;
    localparam int RR_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // First set bit of req at or after last+1, wrapping at n-1 -> 0.
    function automatic int unsigned rr_next(
        input logic [RR_MAX-1:0] req,
        input int unsigned       last,
        input int unsigned       n
    );
        int unsigned result;
        int unsigned idx;
        logic        found;
        result = last;
        found  = 1'b0;
        for (int unsigned k = 32'd1; k <= RR_MAX; k++) begin
            if ((k <= n) && !found) begin
                idx = (last + k) % n;
                if (req[idx[RR_IDX_W-1:0]]) begin
                    result = idx;
                    found  = 1'b1;
                end else begin
                    found  = 1'b0;
                end
            end else begin
                idx = 32'd0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, W cycles per
// division. done_o is high during the final step and quotient_o then carries
// the finished quotient, so the caller can register it on the same edge.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       rem_q, rem_d;
    logic [W-1:0]     quot_q, quot_d;

    logic [W+1:0]     rem_shift_s;
    logic [W:0]       diff_s;
    logic             take_s;
    logic [W-1:0]     step_quot_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, quot_q[W-1]};
        take_s      = (rem_shift_s >= {2'b00, divisor_i});
        diff_s      = rem_shift_s[W:0] - {1'b0, divisor_i};
        step_quot_s = {quot_q[W-2:0], take_s};
        done_o      = active_q && (cnt_q == LAST_STEP);
        quotient_o  = step_quot_s;
    end

    // Next-state for the iteration registers.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
            rem_d    = '0;
            quot_d   = dividend_i;
        end else if (active_q) begin
            rem_d    = take_s ? diff_s : rem_shift_s[W:0];
            quot_d   = step_quot_s;
            cnt_d    = cnt_q + CNT_W'(1);
            active_d = (cnt_q != LAST_STEP);
        end else begin
            active_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
        end
    end

endmodule

// File: rtl/speed_div_scheduler.sv
// Shares one iterative divider across all crossings: per-crossing pending
// slots, round-robin arbitration and the IDLE/DIV/DONE sequencing FSM.
module speed_div_scheduler
    import railway_pkg::*;
#(
    parameter int NUM_CROSSINGS = 4,
    parameter int TIMER_W       = 32,
    parameter int SPEED_SCALE   = DEFAULT_SPEED_SCALE,
    parameter int ID_W          = $clog2(NUM_CROSSINGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CROSSINGS-1:0]         req_valid,
    input  logic [NUM_CROSSINGS*TIMER_W-1:0] req_timer,
    output logic                             speed_valid,
    output logic [TIMER_W-1:0]               speed_val,
    output logic [ID_W-1:0]                  speed_id,
    output logic [NUM_CROSSINGS-1:0]         overrun,
    output logic                             busy
);

    localparam logic [TIMER_W-1:0] SCALE_C    = TIMER_W'(SPEED_SCALE);
    localparam logic [ID_W-1:0]    LAST_CH_C  = ID_W'(NUM_CROSSINGS - 1);

    div_state_e                 state_q, state_d;
    logic [NUM_CROSSINGS-1:0]   pend_q, pend_d;
    logic [TIMER_W-1:0]         slot_q [NUM_CROSSINGS];
    logic [TIMER_W-1:0]         slot_d [NUM_CROSSINGS];
    logic [ID_W-1:0]            last_grant_q, last_grant_d;
    logic [ID_W-1:0]            cur_id_q, cur_id_d;
    logic [TIMER_W-1:0]         divisor_q, divisor_d;
    logic                       rearm_q, rearm_d;
    logic                       speed_valid_q, speed_valid_d;
    logic [TIMER_W-1:0]         speed_val_q, speed_val_d;
    logic [ID_W-1:0]            speed_id_q, speed_id_d;
    logic [NUM_CROSSINGS-1:0]   overrun_q, overrun_d;
    logic                       busy_q, busy_d;

    logic                       grant_s;
    logic [ID_W-1:0]            grant_idx_s;
    logic                       div_start_s;
    logic                       div_done_s;
    logic [TIMER_W-1:0]         div_quot_s;

    seq_divider #(
        .W(TIMER_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start_s),
        .dividend_i(SCALE_C),
        .divisor_i (divisor_q),
        .done_o    (div_done_s),
        .quotient_o(div_quot_s)
    );

    // Arbitration. One idle cycle follows every result before the next grant,
    // which spaces back-to-back results TIMER_W+3 cycles apart.
    always_comb begin
        grant_s     = (state_q == IDLE) && !rearm_q && (|pend_q);
        grant_idx_s = ID_W'(rr_next(RR_MAX'(pend_q), 32'(last_grant_q),
                                    32'(NUM_CROSSINGS)));
    end

    // Pending slots: a new request always wins over a same-cycle grant.
    always_comb begin
        for (int i = 0; i < NUM_CROSSINGS; i++) begin
            logic hit;
            hit          = grant_s && (grant_idx_s == ID_W'(i));
            slot_d[i]    = slot_q[i];
            overrun_d[i] = 1'b0;
            if (req_valid[i]) begin
                pend_d[i]    = 1'b1;
                slot_d[i]    = req_timer[i*TIMER_W +: TIMER_W];
                overrun_d[i] = pend_q[i] && !hit;
            end else if (hit) begin
                pend_d[i]    = 1'b0;
            end else begin
                pend_d[i]    = pend_q[i];
            end
        end
    end

    // Sequencing FSM and result capture.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cur_id_d      = cur_id_q;
        divisor_d     = divisor_q;
        speed_valid_d = 1'b0;
        speed_val_d   = speed_val_q;
        speed_id_d    = speed_id_q;
        div_start_s   = 1'b0;
        rearm_d       = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    last_grant_d = grant_idx_s;
                    cur_id_d     = grant_idx_s;
                    divisor_d    = slot_q[grant_idx_s];
                    if (slot_q[grant_idx_s] == '0) begin
                        state_d       = DONE;
                        speed_valid_d = 1'b1;
                        speed_val_d   = '0;
                        speed_id_d    = grant_idx_s;
                    end else begin
                        state_d     = DIV;
                        div_start_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_d       = DONE;
                    speed_valid_d = 1'b1;
                    speed_val_d   = div_quot_s;
                    speed_id_d    = cur_id_q;
                end else begin
                    state_d = DIV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, slot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            last_grant_q  <= LAST_CH_C;
            cur_id_q      <= '0;
            divisor_q     <= '0;
            rearm_q       <= 1'b0;
            speed_valid_q <= 1'b0;
            speed_val_q   <= '0;
            speed_id_q    <= '0;
            overrun_q     <= '0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_CROSSINGS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            last_grant_q  <= last_grant_d;
            cur_id_q      <= cur_id_d;
            divisor_q     <= divisor_d;
            rearm_q       <= rearm_d;
            speed_valid_q <= speed_valid_d;
            speed_val_q   <= speed_val_d;
            speed_id_q    <= speed_id_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
            for (int i = 0; i < NUM_CROSSINGS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign speed_valid = speed_valid_q;
    assign speed_val   = speed_val_q;
    assign speed_id    = speed_id_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_speed_div_scheduler.sv
// Directed self-checking bench for speed_div_scheduler (4 crossings, 32-bit).
module tb_speed_div_scheduler;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_timer;
    logic           speed_valid;
    logic [W-1:0]   speed_val;
    logic [IDW-1:0] speed_id;
    logic [N-1:0]   overrun;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    speed_div_scheduler #(
        .NUM_CROSSINGS(N),
        .TIMER_W      (W),
        .SPEED_SCALE  (1000000),
        .ID_W         (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_timer  (req_timer),
        .speed_valid(speed_valid),
        .speed_val  (speed_val),
        .speed_id   (speed_id),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_timer = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Posts one request and reports the cycle (relative to the post) of the result.
    task automatic run_one(input int ch, input logic [W-1:0] t,
                           output int cyc, output logic [W-1:0] val, output int id);
        cyc = -1;
        val = '0;
        id  = -1;
        @(posedge clk); #1;
        req_valid[ch]        = 1'b1;
        req_timer[ch*W +: W] = t;
        for (int c = 0; c < 100 && cyc < 0; c++) begin
            @(negedge clk);
            if (speed_valid === 1'b1) begin
                cyc = c;
                val = speed_val;
                id  = int'(speed_id);
            end
            @(posedge clk); #1;
            req_valid = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total += 5;
        if (speed_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", speed_valid); end
        if (speed_val !== '0) begin bad++; $display("FAIL reset_val: got %0d want 0", speed_val); end
        if (speed_id !== '0) begin bad++; $display("FAIL reset_id: got %0d want 0", speed_id); end
        if (overrun !== '0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int cyc; int id; logic [W-1:0] val;
        run_one(2, 32'd1000, cyc, val, id);
        total += 3;
        if (cyc !== 34) begin bad++; $display("FAIL single_cycle: got %0d want 34", cyc); end
        if (val !== 32'd1000) begin bad++; $display("FAIL single_val: got %0d want 1000", val); end
        if (id !== 2) begin bad++; $display("FAIL single_id: got %0d want 2", id); end
    endtask

    task automatic test_zero_and_bounds();
        logic [W-1:0] tv [3] = '{32'd0, 32'd1, 32'd2000000};
        logic [W-1:0] ev [3] = '{32'd0, 32'd1000000, 32'd0};
        int           ec [3] = '{2, 34, 34};
        int cyc; int id; logic [W-1:0] val;
        for (int k = 0; k < 3; k++) begin
            run_one(0, tv[k], cyc, val, id);
            total += 3;
            if (cyc !== ec[k]) begin bad++; $display("FAIL bound%0d_cycle: got %0d want %0d", k, cyc, ec[k]); end
            if (val !== ev[k]) begin bad++; $display("FAIL bound%0d_val: got %0d want %0d", k, val, ev[k]); end
            if (id !== 0) begin bad++; $display("FAIL bound%0d_id: got %0d want 0", k, id); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ev [4] = '{32'd100000, 32'd50000, 32'd25000, 32'd20000};
        int got_id [4]; logic [W-1:0] got_val [4]; int got_cyc [4];
        int got = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin got_id[k] = -1; got_val[k] = '0; got_cyc[k] = -1; end
        req_valid = 4'b1111;
        req_timer = {32'd50, 32'd40, 32'd20, 32'd10};
        for (int c = 0; c < 250 && got < 4; c++) begin
            @(negedge clk);
            if (speed_valid === 1'b1) begin
                got_id[got] = int'(speed_id); got_val[got] = speed_val; got_cyc[got] = c;
                got++;
            end
            @(posedge clk); #1;
            req_valid = '0;
        end
        for (int k = 0; k < 4; k++) begin
            total += 3;
            if (got_id[k] !== k) begin bad++; $display("FAIL b2b%0d_id: got %0d want %0d", k, got_id[k], k); end
            if (got_val[k] !== ev[k]) begin bad++; $display("FAIL b2b%0d_val: got %0d want %0d", k, got_val[k], ev[k]); end
            if (got_cyc[k] !== 34 + 35 * k) begin bad++; $display("FAIL b2b%0d_cycle: got %0d want %0d", k, got_cyc[k], 34 + 35 * k); end
        end
    endtask

    task automatic test_fairness();
        int           eid [4] = '{1, 3, 1, 3};
        logic [W-1:0] ev  [4] = '{32'd10000, 32'd5000, 32'd10000, 32'd5000};
        int got_id [4]; logic [W-1:0] got_val [4];
        int got = 0;
        logic prev_busy = 1'b0;
        logic post1, post3;
        do_reset();
        for (int k = 0; k < 4; k++) begin got_id[k] = -1; got_val[k] = '0; end
        req_valid = 4'b1010;
        req_timer[1*W +: W] = 32'd100;
        req_timer[3*W +: W] = 32'd200;
        for (int c = 0; c < 300 && got < 4; c++) begin
            @(negedge clk);
            post1 = (busy === 1'b1) && !prev_busy;
            prev_busy = busy;
            post3 = 1'b0;
            if (speed_valid === 1'b1) begin
                got_id[got] = int'(speed_id); got_val[got] = speed_val;
                post3 = (speed_id == 2'd3);
                got++;
            end
            @(posedge clk); #1;
            req_valid = '0;
            if (post1) begin req_valid[1] = 1'b1; req_timer[1*W +: W] = 32'd100; end
            if (post3) begin req_valid[3] = 1'b1; req_timer[3*W +: W] = 32'd200; end
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            total += 2;
            if (got_id[k] !== eid[k]) begin bad++; $display("FAIL fair%0d_id: got %0d want %0d", k, got_id[k], eid[k]); end
            if (got_val[k] !== ev[k]) begin bad++; $display("FAIL fair%0d_val: got %0d want %0d", k, got_val[k], ev[k]); end
        end
    endtask

    task automatic test_overrun();
        int ov1 = 0; int ov_other = 0;
        int got_id [2]; logic [W-1:0] got_val [2]; int got_cyc [2];
        int got = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin got_id[k] = -1; got_val[k] = '0; got_cyc[k] = -1; end
        for (int c = 0; c < 120 && got < 2; c++) begin
            req_valid = '0;
            if (c == 0)  begin req_valid[0] = 1'b1; req_timer[0*W +: W] = 32'd1000; end
            if (c == 5)  begin req_valid[1] = 1'b1; req_timer[1*W +: W] = 32'd500; end
            if (c == 10) begin req_valid[1] = 1'b1; req_timer[1*W +: W] = 32'd250; end
            @(negedge clk);
            if (overrun[1] === 1'b1) ov1++;
            if ((overrun & 4'b1101) !== 4'b0000) ov_other++;
            if (speed_valid === 1'b1) begin
                got_id[got] = int'(speed_id); got_val[got] = speed_val; got_cyc[got] = c;
                got++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        total += 6;
        if (ov1 !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ov1); end
        if (ov_other !== 0) begin bad++; $display("FAIL ovr_other: got %0d want 0", ov_other); end
        if (got_id[0] !== 0 || got_val[0] !== 32'd1000) begin
            bad++; $display("FAIL ovr_first: got id %0d val %0d want id 0 val 1000", got_id[0], got_val[0]);
        end
        if (got_id[1] !== 1) begin bad++; $display("FAIL ovr_id: got %0d want 1", got_id[1]); end
        if (got_val[1] !== 32'd4000) begin bad++; $display("FAIL ovr_val: got %0d want 4000", got_val[1]); end
        if (got_cyc[1] !== 69) begin bad++; $display("FAIL ovr_cycle: got %0d want 69", got_cyc[1]); end
    endtask

    task automatic test_reset_mid_div();
        int spurious = 0;
        logic busy_after = 1'bx;
        int cyc; int id; logic [W-1:0] val;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            req_valid = '0;
            rst = (c == 11);
            if (c == 0) begin req_valid[0] = 1'b1; req_timer[0*W +: W] = 32'd7; end
            if (c == 3) begin req_valid[2] = 1'b1; req_timer[2*W +: W] = 32'd100; end
            @(negedge clk);
            if (speed_valid === 1'b1) spurious++;
            if (c == 13) busy_after = busy;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req_valid = '0;
        total += 2;
        if (spurious !== 0) begin bad++; $display("FAIL rstmid_valid: got %0d pulses want 0", spurious); end
        if (busy_after !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy_after); end
        run_one(3, 32'd400, cyc, val, id);
        total += 3;
        if (id !== 3) begin bad++; $display("FAIL rstmid_id: got %0d want 3", id); end
        if (val !== 32'd2500) begin bad++; $display("FAIL rstmid_val: got %0d want 2500", val); end
        if (cyc !== 34) begin bad++; $display("FAIL rstmid_cycle: got %0d want 34", cyc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_and_bounds();
        test_back_to_back();
        test_fairness();
        test_overrun();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
